traffic_light_ctrl: RTL and testbench

Parametrised multi-phase traffic-light controller, the successor to the fixed 2-way, 6-state light FSM. It serves NUM_PHASES approach directions in round-robin order: green, then yellow, then all-red. Adds an internal tick prescaler, per-phase enable mask, latched pedestrian requests with green extension and walk signal, and a night mode that flashes yellow on every phase. Sits at the top of the intersection FPGA design and drives lamp drivers directly.

---
 rtl/traffic_light_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - multi-phase round-robin traffic-light controller
// Prescaled tick timing, phase enable mask, latched pedestrian requests and night flash.
module traffic_light_ctrl #(
   parameter int NUM_PHASES   = 2,
   parameter int CLK_PER_TICK = 50000000,
   parameter int GREEN_T      = 5,
   parameter int YELLOW_T     = 1,
   parameter int ALLRED_T     = 1,
   parameter int PED_EXT      = 2,
   parameter int CNT_W        = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    night,
   input  logic [NUM_PHASES-1:0]   phase_en,
   input  logic [NUM_PHASES-1:0]   ped_req,
   output logic [3*NUM_PHASES-1:0] lights,
   output logic [NUM_PHASES-1:0]   ped_walk,
   output logic [2:0]              cur_phase
);

   typedef enum logic [1:0] {S_ALLRED, S_GREEN, S_YELLOW, S_FLASH} state_t;

   localparam int PW   = $clog2(NUM_PHASES);
   localparam int PC_W = $clog2(CLK_PER_TICK);

   localparam logic [PC_W-1:0]  PC_LAST = PC_W'(CLK_PER_TICK - 1);
   localparam logic [CNT_W-1:0] AR_LIM  = CNT_W'(ALLRED_T);
   localparam logic [CNT_W-1:0] AR_END  = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] Y_END   = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] G_END   = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] GP_END  = CNT_W'(GREEN_T + PED_EXT - 1);

   state_t                  r_state;
   logic [PW-1:0]           r_p;
   logic [CNT_W-1:0]        r_t;
   logic [PC_W-1:0]         r_pc;
   logic                    r_f;
   logic [NUM_PHASES-1:0]   r_pl;
   logic                    r_srv;
   logic                    r_from0;
   logic [3*NUM_PHASES-1:0] r_lights;
   logic [NUM_PHASES-1:0]   r_walk;

   logic                    w_tick;
   logic [NUM_PHASES-1:0]   w_pl_in;
   logic                    w_found;
   logic [PW-1:0]           w_sel;
   logic                    w_expire;
   logic [CNT_W-1:0]        w_g_end;

   state_t                  w_nstate;
   logic [PW-1:0]           w_np;
   logic [CNT_W-1:0]        w_nt;
   logic [PC_W-1:0]         w_npc;
   logic                    w_nf;
   logic [NUM_PHASES-1:0]   w_npl;
   logic                    w_nsrv;
   logic                    w_nfrom0;
   logic [3*NUM_PHASES-1:0] w_nlights;
   logic [NUM_PHASES-1:0]   w_nwalk;

   assign w_tick   = (r_pc == PC_LAST);
   assign w_pl_in  = r_pl | ped_req;
   assign w_expire = (r_t == AR_LIM) || (w_tick && (r_t == AR_END));
   assign w_g_end  = r_srv ? GP_END : G_END;

   // Round-robin search: start after p so p itself is the last candidate.
   always_comb begin
      int start;
      int idx;
      w_found = 1'b0;
      w_sel   = '0;
      start   = r_from0 ? 0 : int'(r_p) + 1;
      if (start >= NUM_PHASES) start = 0;
      for (int k = 0; k < NUM_PHASES; k++) begin
         idx = start + k;
         if (idx >= NUM_PHASES) idx = idx - NUM_PHASES;
         if (!w_found && phase_en[PW'(idx)]) begin
            w_found = 1'b1;
            w_sel   = PW'(idx);
         end
      end
   end

   always_comb begin
      w_nstate = r_state;
      w_np     = r_p;
      w_nt     = r_t;
      w_npc    = w_tick ? '0 : r_pc + PC_W'(1);
      w_nf     = r_f;
      w_npl    = w_pl_in;
      w_nsrv   = r_srv;
      w_nfrom0 = r_from0;
      case (r_state)
         S_ALLRED: begin
            if (w_expire) begin
               w_npc = '0;
               w_nt  = '0;
               if (night) begin
                  w_nstate = S_FLASH;
                  w_nf     = 1'b1;
               end else if (w_found) begin
                  w_nstate     = S_GREEN;
                  w_np         = w_sel;
                  w_nsrv       = w_pl_in[w_sel];
                  w_npl[w_sel] = 1'b0;
                  w_nfrom0     = 1'b0;
               end else begin
                  // No enabled phase: hold expired and retry every cycle.
                  w_nt = AR_LIM;
               end
            end else if (w_tick) begin
               w_nt = r_t + CNT_W'(1);
            end
         end
         S_GREEN: begin
            if (night || (w_tick && r_t == w_g_end)) begin
               w_nstate = S_YELLOW;
               w_npc    = '0;
               w_nt     = '0;
               w_nsrv   = 1'b0;
            end else if (w_tick) begin
               w_nt = r_t + CNT_W'(1);
            end
         end
         S_YELLOW: begin
            if (w_tick && r_t == Y_END) begin
               w_nstate = S_ALLRED;
               w_npc    = '0;
               w_nt     = '0;
            end else if (w_tick) begin
               w_nt = r_t + CNT_W'(1);
            end
         end
         default: begin
            if (!night) begin
               w_nstate = S_ALLRED;
               w_npc    = '0;
               w_nt     = '0;
               w_nf     = 1'b0;
               w_nfrom0 = 1'b1;
            end else if (w_tick) begin
               w_nf = ~r_f;
            end
         end
      endcase
   end

   always_comb begin
      w_nlights = '0;
      w_nwalk   = '0;
      for (int i = 0; i < NUM_PHASES; i++) begin
         case (w_nstate)
            S_GREEN:  w_nlights[3*i +: 3] = (w_np == PW'(i)) ? 3'b100 : 3'b001;
            S_YELLOW: w_nlights[3*i +: 3] = (w_np == PW'(i)) ? 3'b010 : 3'b001;
            S_FLASH:  w_nlights[3*i +: 3] = w_nf ? 3'b010 : 3'b000;
            default:  w_nlights[3*i +: 3] = 3'b001;
         endcase
         w_nwalk[i] = (w_nstate == S_GREEN) && w_nsrv && (w_np == PW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_ALLRED;
         r_p      <= '0;
         r_t      <= '0;
         r_pc     <= '0;
         r_f      <= 1'b0;
         r_pl     <= '0;
         r_srv    <= 1'b0;
         r_from0  <= 1'b1;
         r_lights <= {NUM_PHASES{3'b001}};
         r_walk   <= '0;
      end else begin
         r_state  <= w_nstate;
         r_p      <= w_np;
         r_t      <= w_nt;
         r_pc     <= w_npc;
         r_f      <= w_nf;
         r_pl     <= w_npl;
         r_srv    <= w_nsrv;
         r_from0  <= w_nfrom0;
         r_lights <= w_nlights;
         r_walk   <= w_nwalk;
      end
   end

   assign lights    = r_lights;
   assign ped_walk  = r_walk;
   assign cur_phase = 3'(r_p);

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - directed bench for traffic_light_ctrl
// Each segment checks lights/walk/cur_phase on every cycle for its expected duration.
module tb_traffic_light_ctrl;

   logic       clk;
   logic       rst;
   logic       night;
   logic [2:0] phase_en;
   logic [2:0] ped_req;
   logic [8:0] lights;
   logic [2:0] ped_walk;
   logic [2:0] cur_phase;

   int checks = 0;
   int errors = 0;

   localparam logic [8:0] RED  = 9'b001_001_001;
   localparam logic [8:0] G0   = 9'b001_001_100;
   localparam logic [8:0] Y0   = 9'b001_001_010;
   localparam logic [8:0] G1   = 9'b001_100_001;
   localparam logic [8:0] Y1   = 9'b001_010_001;
   localparam logic [8:0] G2   = 9'b100_001_001;
   localparam logic [8:0] Y2   = 9'b010_001_001;
   localparam logic [8:0] FON  = 9'b010_010_010;
   localparam logic [8:0] FOFF = 9'b000_000_000;

   traffic_light_ctrl #(
      .NUM_PHASES(3), .CLK_PER_TICK(4), .GREEN_T(3), .YELLOW_T(1),
      .ALLRED_T(1), .PED_EXT(2), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .night(night), .phase_en(phase_en),
      .ped_req(ped_req), .lights(lights), .ped_walk(ped_walk), .cur_phase(cur_phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic seg(input logic [8:0] el, input logic [2:0] ew, input logic [2:0] ec,
                      input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         checks++;
         assert ({lights, ped_walk, cur_phase} === {el, ew, ec}) else begin
            errors++;
            $error("FAIL %s cyc %0d: got lights=%b walk=%b cur=%0d, want lights=%b walk=%b cur=%0d",
                   tag, k, lights, ped_walk, cur_phase, el, ew, ec);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b0; night = 1'b0; phase_en = 3'b111; ped_req = 3'b000;
      repeat (3) @(negedge clk);
      seg(RED, 3'b000, 3'd0, 1, "reset");
      rst = 1'b1;

      seg(RED, 3'b000, 3'd0, 4, "init_red");
      seg(G0,  3'b000, 3'd0, 12, "g0_a");
      seg(Y0,  3'b000, 3'd0, 4, "y0_a");
      seg(RED, 3'b000, 3'd0, 4, "r0_a");
      seg(G1,  3'b000, 3'd1, 12, "g1_a");
      seg(Y1,  3'b000, 3'd1, 4, "y1_a");
      seg(RED, 3'b000, 3'd1, 4, "r1_a");
      seg(G2,  3'b000, 3'd2, 12, "g2_a");
      seg(Y2,  3'b000, 3'd2, 4, "y2_a");
      seg(RED, 3'b000, 3'd2, 4, "r2_a");
      seg(G0,  3'b000, 3'd0, 12, "g0_b");

      phase_en = 3'b101;
      seg(Y0,  3'b000, 3'd0, 4, "y0_b");
      seg(RED, 3'b000, 3'd0, 4, "r0_b");
      seg(G2,  3'b000, 3'd2, 12, "g2_skip1");
      seg(Y2,  3'b000, 3'd2, 4, "y2_b");
      seg(RED, 3'b000, 3'd2, 4, "r2_b");
      seg(G0,  3'b000, 3'd0, 5, "g0_c");
      ped_req = 3'b100;
      seg(G0,  3'b000, 3'd0, 1, "g0_c_ped");
      ped_req = 3'b000;
      seg(G0,  3'b000, 3'd0, 6, "g0_c_end");
      seg(Y0,  3'b000, 3'd0, 4, "y0_c");
      seg(RED, 3'b000, 3'd0, 4, "r0_c");
      seg(G2,  3'b100, 3'd2, 20, "g2_walk");
      seg(Y2,  3'b000, 3'd2, 4, "y2_walk");
      seg(RED, 3'b000, 3'd2, 4, "r2_c");
      seg(G0,  3'b000, 3'd0, 12, "g0_d");
      seg(Y0,  3'b000, 3'd0, 4, "y0_d");
      seg(RED, 3'b000, 3'd0, 4, "r0_d");
      seg(G2,  3'b000, 3'd2, 12, "g2_nowalk");

      phase_en = 3'b000;
      seg(Y2,  3'b000, 3'd2, 4, "y2_d");
      seg(RED, 3'b000, 3'd2, 44, "none_en");
      phase_en = 3'b111;
      seg(RED, 3'b000, 3'd2, 1, "reen");
      seg(G0,  3'b000, 3'd0, 12, "g0_e");
      seg(Y0,  3'b000, 3'd0, 4, "y0_e");
      seg(RED, 3'b000, 3'd0, 4, "r0_e");
      seg(G1,  3'b000, 3'd1, 5, "g1_night");

      night = 1'b1;
      seg(G1,  3'b000, 3'd1, 1, "g1_last");
      seg(Y1,  3'b000, 3'd1, 4, "y1_night");
      seg(RED, 3'b000, 3'd1, 4, "r1_night");
      seg(FON, 3'b000, 3'd1, 4, "flash_on1");
      ped_req = 3'b010;
      seg(FOFF, 3'b000, 3'd1, 1, "flash_off1_ped");
      ped_req = 3'b000;
      seg(FOFF, 3'b000, 3'd1, 3, "flash_off1");
      seg(FON,  3'b000, 3'd1, 4, "flash_on2");
      night = 1'b0;
      seg(FOFF, 3'b000, 3'd1, 1, "flash_exit");
      seg(RED,  3'b000, 3'd1, 4, "day_red");
      seg(G0,   3'b000, 3'd0, 12, "day_g0");
      seg(Y0,   3'b000, 3'd0, 4, "day_y0");
      seg(RED,  3'b000, 3'd0, 4, "day_r0");
      seg(G1,   3'b010, 3'd1, 20, "g1_flashped");

      ped_req = 3'b001;
      seg(Y1, 3'b000, 3'd1, 1, "y1_ped0");
      ped_req = 3'b000;
      seg(Y1, 3'b000, 3'd1, 1, "y1_pre_rst");
      #2 rst = 1'b0;
      #1;
      checks++;
      assert ({lights, ped_walk, cur_phase} === {RED, 3'b000, 3'd0}) else begin
         errors++;
         $error("FAIL async_rst: got lights=%b walk=%b cur=%0d, want lights=%b walk=000 cur=0",
                lights, ped_walk, cur_phase, RED);
      end
      @(negedge clk);
      rst = 1'b1;
      seg(RED, 3'b000, 3'd0, 4, "post_rst_red");
      seg(G0,  3'b000, 3'd0, 12, "post_rst_g0");
      seg(Y0,  3'b000, 3'd0, 4, "post_rst_y0");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
